// File: rtl/multicycle_alu_controller.sv
// ============================================================================
// Module   : multicycle_alu_controller
// Brief    : Multi-cycle IF/ID/EX/MEM/WB control FSM for an RV32I subset core
//            driving ALU commands, datapath selects and register enables.
//            Build option ILLEGAL_TRAP_EN: unsupported encodings trap instead
//            of retiring as a NOP.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_alu_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       inst_opcode,
    input  logic [2:0]       inst_funct3,
    input  logic             inst_funct7_5,
    input  logic             alu_bcond,
    input  logic             mem_ready,
    output logic [4:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_source,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             is_halted,
    output logic             illegal_inst,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [3:0]       state_dbg
);

    // ALU command codes shared with the datapath command decoder
    localparam logic [4:0] c_ALU_ADD  = 5'd1;
    localparam logic [4:0] c_ALU_SUB  = 5'd2;
    localparam logic [4:0] c_ALU_SLL  = 5'd3;
    localparam logic [4:0] c_ALU_XOR  = 5'd4;
    localparam logic [4:0] c_ALU_SRL  = 5'd5;
    localparam logic [4:0] c_ALU_OR   = 5'd6;
    localparam logic [4:0] c_ALU_AND  = 5'd7;
    localparam logic [4:0] c_ALU_LW   = 5'd8;
    localparam logic [4:0] c_ALU_SW   = 5'd9;
    localparam logic [4:0] c_ALU_BEQ  = 5'd10;
    localparam logic [4:0] c_ALU_BNE  = 5'd11;
    localparam logic [4:0] c_ALU_BLT  = 5'd12;
    localparam logic [4:0] c_ALU_BGE  = 5'd13;
    localparam logic [4:0] c_ALU_JALR = 5'd14;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_SYS   = 7'b1110011;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_MEM  = 4'd7,
        S_WB_ALU  = 4'd8,
        S_EX_BR   = 4'd9,
        S_EX_JAL  = 4'd10,
        S_EX_JALR = 4'd11,
        S_HALT    = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t c_ILL_NEXT = S_TRAP;
`else
    localparam state_t c_ILL_NEXT = S_IF;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_retired_cnt;
    state_t           w_id_next;
    logic [4:0]       w_r_op;
    logic [4:0]       w_i_op;
    logic [4:0]       w_br_op;
    logic             w_r_legal;
    logic             w_i_legal;
    logic             w_br_legal;

    // funct decode; SUB is the only funct7 variant, shifts need funct7_5 = 0
    always_comb begin
        w_r_op     = c_ALU_ADD;
        w_i_op     = c_ALU_ADD;
        w_br_op    = c_ALU_BEQ;
        w_r_legal  = 1'b0;
        w_i_legal  = 1'b0;
        w_br_legal = 1'b0;
        case (inst_funct3)
            3'b000: begin
                w_r_op    = inst_funct7_5 ? c_ALU_SUB : c_ALU_ADD;
                w_i_op    = c_ALU_ADD;
                w_br_op   = c_ALU_BEQ;
                w_r_legal = 1'b1;
                w_i_legal = 1'b1;
                w_br_legal = 1'b1;
            end
            3'b001: begin
                w_r_op     = c_ALU_SLL;
                w_i_op     = c_ALU_SLL;
                w_br_op    = c_ALU_BNE;
                w_r_legal  = !inst_funct7_5;
                w_i_legal  = !inst_funct7_5;
                w_br_legal = 1'b1;
            end
            3'b100: begin
                w_r_op     = c_ALU_XOR;
                w_i_op     = c_ALU_XOR;
                w_br_op    = c_ALU_BLT;
                w_r_legal  = !inst_funct7_5;
                w_i_legal  = 1'b1;
                w_br_legal = 1'b1;
            end
            3'b101: begin
                w_r_op     = c_ALU_SRL;
                w_i_op     = c_ALU_SRL;
                w_br_op    = c_ALU_BGE;
                w_r_legal  = !inst_funct7_5;
                w_i_legal  = !inst_funct7_5;
                w_br_legal = 1'b1;
            end
            3'b110: begin
                w_r_op    = c_ALU_OR;
                w_i_op    = c_ALU_OR;
                w_r_legal = !inst_funct7_5;
                w_i_legal = 1'b1;
            end
            3'b111: begin
                w_r_op    = c_ALU_AND;
                w_i_op    = c_ALU_AND;
                w_r_legal = !inst_funct7_5;
                w_i_legal = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_id_next = c_ILL_NEXT;
        case (inst_opcode)
            c_OP_R:     if (w_r_legal)  w_id_next = S_EX_R;
            c_OP_I:     if (w_i_legal)  w_id_next = S_EX_I;
            c_OP_LOAD,
            c_OP_STORE: if (inst_funct3 == 3'b010) w_id_next = S_EX_ADDR;
            c_OP_BR:    if (w_br_legal) w_id_next = S_EX_BR;
            c_OP_JAL:   w_id_next = S_EX_JAL;
            c_OP_JALR:  if (inst_funct3 == 3'b000) w_id_next = S_EX_JALR;
            c_OP_SYS:   w_id_next = S_HALT;
            default:    ;
        endcase
    end

    // Every return to IF from a later state retires one instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IF;
            r_retired_cnt <= '0;
        end else begin
            case (r_state)
                S_IF:      if (mem_ready) r_state <= S_ID;
                S_ID: begin
                    r_state <= w_id_next;
                    if (w_id_next == S_IF) r_retired_cnt <= r_retired_cnt + 1'b1;
                end
                S_EX_R,
                S_EX_I:    r_state <= S_WB_ALU;
                S_EX_ADDR: r_state <= inst_opcode[5] ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:  if (mem_ready) r_state <= S_WB_MEM;
                S_MEM_WR: begin
                    if (mem_ready) begin
                        r_state       <= S_IF;
                        r_retired_cnt <= r_retired_cnt + 1'b1;
                    end
                end
                S_WB_MEM, S_WB_ALU, S_EX_BR, S_EX_JAL, S_EX_JALR: begin
                    r_state       <= S_IF;
                    r_retired_cnt <= r_retired_cnt + 1'b1;
                end
                S_HALT, S_TRAP: r_state <= r_state;
                default:   r_state <= S_IF;
            endcase
        end
    end

    always_comb begin
        alu_op       = c_ALU_ADD;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        i_or_d       = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_source    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        is_halted    = 1'b0;
        illegal_inst = 1'b0;
        case (r_state)
            S_IF: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_ID: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_EX_R: begin
                alu_op    = w_r_op;
                alu_src_a = 2'b01;
            end
            S_EX_I: begin
                alu_op    = w_i_op;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_EX_ADDR: begin
                alu_op    = inst_opcode[5] ? c_ALU_SW : c_ALU_LW;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
            end
            S_WB_ALU:  reg_write = 1'b1;
            S_EX_BR: begin
                alu_op    = w_br_op;
                alu_src_a = 2'b01;
                pc_write  = alu_bcond;
                pc_source = 1'b1;
            end
            S_EX_JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_source = 1'b1;
            end
            S_EX_JALR: begin
                alu_op    = c_ALU_JALR;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
            end
            S_HALT:    is_halted = 1'b1;
            S_TRAP: begin
                is_halted    = 1'b1;
                illegal_inst = 1'b1;
            end
            default: ;
        endcase
        // Outputs are forced quiet for the whole time reset is held
        if (reset) begin
            alu_op       = 5'd0;
            alu_src_a    = 2'b00;
            alu_src_b    = 2'b00;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            i_or_d       = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_source    = 1'b0;
            reg_write    = 1'b0;
            wb_sel       = 2'b00;
            is_halted    = 1'b0;
            illegal_inst = 1'b0;
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign state_dbg   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu_controller.sv
// ============================================================================
// Module   : tb_multicycle_alu_controller
// Brief    : Directed plus randomized instruction streams for the multi-cycle
//            controller, checked cycle by cycle against an instruction-level
//            model. Honors ILLEGAL_TRAP_EN like the design.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_alu_controller;

    localparam logic [4:0] ADD = 5'd1, SUB = 5'd2, SLL = 5'd3, XOR = 5'd4, SRL = 5'd5,
                           OR  = 5'd6, AND = 5'd7, LW  = 5'd8, SW  = 5'd9, BEQ = 5'd10,
                           BNE = 5'd11, BLT = 5'd12, BGE = 5'd13, JALR = 5'd14;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5,
                   K_JALR = 6, K_HALT = 7, K_ILL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  inst_opcode = '0;
    logic [2:0]  inst_funct3 = '0;
    logic        inst_funct7_5 = 1'b0;
    logic        alu_bcond = 1'b0;
    logic        mem_ready = 1'b0;
    logic [4:0]  alu_op;
    logic [1:0]  alu_src_a, alu_src_b, wb_sel;
    logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source, reg_write;
    logic        is_halted, illegal_inst;
    logic [31:0] retired_cnt;
    logic [3:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    always #5 clk = ~clk;

    multicycle_alu_controller dut (
        .clk(clk), .reset(reset), .inst_opcode(inst_opcode), .inst_funct3(inst_funct3),
        .inst_funct7_5(inst_funct7_5), .alu_bcond(alu_bcond), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_req(mem_req),
        .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .reg_write(reg_write), .wb_sel(wb_sel), .is_halted(is_halted),
        .illegal_inst(illegal_inst), .retired_cnt(retired_cnt), .state_dbg(state_dbg)
    );

    logic [10:0] obs_ctl;
    assign obs_ctl = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source,
                      reg_write, wb_sel, is_halted, illegal_inst};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk(input bit mreq, mwe, iord, irw, pcw, pcs, rw,
                                       input bit [1:0] wb, input bit hl, il);
        return {mreq, mwe, iord, irw, pcw, pcs, rw, wb, hl, il};
    endfunction

    // Instruction class from the supported RV32I subset
    function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (op)
            7'b0110011: return (f3 == 3'd0 || (!f7 && f3 inside {3'd1, 3'd4, 3'd5, 3'd6, 3'd7})) ? K_R : K_ILL;
            7'b0010011: return (f3 inside {3'd0, 3'd4, 3'd6, 3'd7} || (!f7 && f3 inside {3'd1, 3'd5})) ? K_I : K_ILL;
            7'b0000011: return (f3 == 3'd2) ? K_LD : K_ILL;
            7'b0100011: return (f3 == 3'd2) ? K_ST : K_ILL;
            7'b1100011: return (f3 inside {3'd0, 3'd1, 3'd4, 3'd5}) ? K_BR : K_ILL;
            7'b1101111: return K_JAL;
            7'b1100111: return (f3 == 3'd0) ? K_JALR : K_ILL;
            7'b1110011: return K_HALT;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [4:0] arith_op(input logic [2:0] f3, input bit sub);
        case (f3)
            3'd0:    return sub ? SUB : ADD;
            3'd1:    return SLL;
            3'd4:    return XOR;
            3'd5:    return SRL;
            3'd6:    return OR;
            default: return AND;
        endcase
    endfunction

    function automatic logic [4:0] branch_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return BEQ;
            3'd1:    return BNE;
            3'd4:    return BLT;
            default: return BGE;
        endcase
    endfunction

    // Inputs are already driven; sample mid-cycle, then advance one clock
    task automatic step(input string tag, input logic [3:0] st, input logic [10:0] ctl,
                        input bit acare, input logic [4:0] aop, input logic [1:0] sa, sb);
        @(negedge clk);
        check_eq({tag, ":state"}, 32'(state_dbg), 32'(st));
        check_eq({tag, ":ctl"}, 32'(obs_ctl), 32'(ctl));
        if (acare) check_eq({tag, ":alu"}, 32'({alu_op, alu_src_a, alu_src_b}), 32'({aop, sa, sb}));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_eq({tag, ":rst_outs"}, 32'({alu_op, alu_src_a, alu_src_b, obs_ctl, state_dbg}), 32'd0);
        check_eq({tag, ":rst_cnt"}, retired_cnt, 32'd0);
        @(negedge clk);
        check_eq({tag, ":rst_outs_late"}, 32'({alu_op, alu_src_a, alu_src_b, obs_ctl, state_dbg}), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        exp_ret   = 0;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int ifw, input int memw, input logic bc);
        int k;
        k = classify(op, f3, f7);
        inst_opcode   = op;
        inst_funct3   = f3;
        inst_funct7_5 = f7;
        alu_bcond     = bc;
        mem_ready     = 1'b0;
        check_eq("retired", retired_cnt, 32'(exp_ret));
        for (int i = 0; i < ifw; i++) step("if_wait", 4'd0, mk(1,0,0,0,0,0,0,2'd0,0,0), 1, ADD, 2'd0, 2'd1);
        mem_ready = 1'b1;
        step("if_done", 4'd0, mk(1,0,0,1,1,0,0,2'd0,0,0), 1, ADD, 2'd0, 2'd1);
        mem_ready = 1'($urandom);
        step("id", 4'd1, 11'd0, 1, ADD, 2'd2, 2'd2);
        mem_ready = 1'($urandom);
        case (k)
            K_R: begin
                step("ex_r", 4'd2, 11'd0, 1, arith_op(f3, f7), 2'd1, 2'd0);
                step("wb_alu", 4'd8, mk(0,0,0,0,0,0,1,2'd0,0,0), 0, 5'd0, 2'd0, 2'd0);
                exp_ret++;
            end
            K_I: begin
                step("ex_i", 4'd3, 11'd0, 1, arith_op(f3, 1'b0), 2'd1, 2'd2);
                step("wb_alu", 4'd8, mk(0,0,0,0,0,0,1,2'd0,0,0), 0, 5'd0, 2'd0, 2'd0);
                exp_ret++;
            end
            K_LD, K_ST: begin
                step("ex_addr", 4'd4, 11'd0, 1, (k == K_LD) ? LW : SW, 2'd1, 2'd2);
                for (int i = 0; i < memw; i++) begin
                    mem_ready = 1'b0;
                    step("mem_wait", (k == K_LD) ? 4'd5 : 4'd6,
                         mk(1, k == K_ST, 1,0,0,0,0,2'd0,0,0), 0, 5'd0, 2'd0, 2'd0);
                end
                mem_ready = 1'b1;
                step("mem_done", (k == K_LD) ? 4'd5 : 4'd6,
                     mk(1, k == K_ST, 1,0,0,0,0,2'd0,0,0), 0, 5'd0, 2'd0, 2'd0);
                mem_ready = 1'($urandom);
                if (k == K_LD) step("wb_mem", 4'd7, mk(0,0,0,0,0,0,1,2'd1,0,0), 0, 5'd0, 2'd0, 2'd0);
                exp_ret++;
            end
            K_BR: begin
                step("ex_br", 4'd9, mk(0,0,0,0,bc,1,0,2'd0,0,0), 1, branch_op(f3), 2'd1, 2'd0);
                exp_ret++;
            end
            K_JAL: begin
                step("ex_jal", 4'd10, mk(0,0,0,0,1,1,1,2'd2,0,0), 0, 5'd0, 2'd0, 2'd0);
                exp_ret++;
            end
            K_JALR: begin
                step("ex_jalr", 4'd11, mk(0,0,0,0,1,0,1,2'd2,0,0), 1, JALR, 2'd1, 2'd2);
                exp_ret++;
            end
            K_HALT: begin
                for (int i = 0; i < 3; i++) begin
                    mem_ready = 1'($urandom);
                    step("halt", 4'd12, mk(0,0,0,0,0,0,0,2'd0,1,0), 0, 5'd0, 2'd0, 2'd0);
                end
                check_eq("halt_cnt", retired_cnt, 32'(exp_ret));
                do_reset("halt");
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++) begin
                    mem_ready = 1'($urandom);
                    step("trap", 4'd13, mk(0,0,0,0,0,0,0,2'd0,1,1), 0, 5'd0, 2'd0, 2'd0);
                end
                do_reset("trap");
`else
                exp_ret++;
`endif
            end
        endcase
    endtask

    logic [6:0] r_op;

    initial begin
        @(negedge clk);
        check_eq("por_outs", 32'({alu_op, alu_src_a, alu_src_b, obs_ctl, state_dbg}), 32'd0);
        check_eq("por_cnt", retired_cnt, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, 1'b0);  // ADD
        run_instr(7'b0000011, 3'd2, 1'b0, 1, 3, 1'b0);  // LW, late memory
        run_instr(7'b1100011, 3'd0, 1'b0, 0, 0, 1'b1);  // BEQ taken
        run_instr(7'b1100011, 3'd0, 1'b0, 0, 0, 1'b0);  // BEQ not taken
        run_instr(7'b1100111, 3'd0, 1'b0, 0, 0, 1'b0);  // JALR
        run_instr(7'b0100011, 3'd2, 1'b0, 2, 0, 1'b0);  // SW, zero-wait
        run_instr(7'b1101111, 3'd3, 1'b1, 0, 0, 1'b0);  // JAL
        run_instr(7'b0110011, 3'd0, 1'b1, 0, 0, 1'b0);  // SUB
        run_instr(7'b0110111, 3'd0, 1'b0, 0, 0, 1'b0);  // LUI, unsupported
        run_instr(7'b0110011, 3'd5, 1'b0, 0, 0, 1'b0);  // SRL
        run_instr(7'b1110011, 3'd0, 1'b0, 0, 0, 1'b0);  // ECALL, then reset

        // Reset in the middle of a load access; the late ready must not leak
        inst_opcode = 7'b0000011; inst_funct3 = 3'd2; inst_funct7_5 = 1'b0;
        mem_ready = 1'b1;
        step("mid_if", 4'd0, mk(1,0,0,1,1,0,0,2'd0,0,0), 1, ADD, 2'd0, 2'd1);
        step("mid_id", 4'd1, 11'd0, 1, ADD, 2'd2, 2'd2);
        step("mid_ex", 4'd4, 11'd0, 1, LW, 2'd1, 2'd2);
        mem_ready = 1'b0;
        step("mid_mem", 4'd5, mk(1,0,1,0,0,0,0,2'd0,0,0), 0, 5'd0, 2'd0, 2'd0);
        do_reset("mid");
        step("mid_after", 4'd0, mk(1,0,0,0,0,0,0,2'd0,0,0), 1, ADD, 2'd0, 2'd1);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 10))
                0, 9: r_op = 7'b0110011;
                1:    r_op = 7'b0010011;
                2:    r_op = 7'b0000011;
                3:    r_op = 7'b0100011;
                4:    r_op = 7'b1100011;
                5:    r_op = 7'b1101111;
                6:    r_op = 7'b1100111;
                7:    r_op = 7'b0110111;
                8:    r_op = 7'($urandom);
                default: r_op = (n % 20 == 19) ? 7'b1110011 : 7'b0010011;
            endcase
            run_instr(r_op, 3'($urandom), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom));
        end
        check_eq("final_cnt", retired_cnt, 32'(exp_ret));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
